// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants and FSM encoding for the matrix loader
package matrix_pkg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } load_state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

endpackage

// File: rtl/reg_bank_16.sv
// rtl/reg_bank_16.sv - 16x16 write-enabled register bank with parallel outputs
module reg_bank_16
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic [DATA_W-1:0] reg6,
  output logic [DATA_W-1:0] reg7,
  output logic [DATA_W-1:0] reg8,
  output logic [DATA_W-1:0] reg9,
  output logic [DATA_W-1:0] reg10,
  output logic [DATA_W-1:0] reg11,
  output logic [DATA_W-1:0] reg12,
  output logic [DATA_W-1:0] reg13,
  output logic [DATA_W-1:0] reg14,
  output logic [DATA_W-1:0] reg15
);

  logic [DATA_W-1:0] bank_q [DEPTH];

  // clr wins over a write in the same cycle so a cleared bank is entirely zero
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else if (wr_en) begin
      bank_q[wr_idx] <= wr_data;
    end
  end

  assign reg0  = bank_q[0];
  assign reg1  = bank_q[1];
  assign reg2  = bank_q[2];
  assign reg3  = bank_q[3];
  assign reg4  = bank_q[4];
  assign reg5  = bank_q[5];
  assign reg6  = bank_q[6];
  assign reg7  = bank_q[7];
  assign reg8  = bank_q[8];
  assign reg9  = bank_q[9];
  assign reg10 = bank_q[10];
  assign reg11 = bank_q[11];
  assign reg12 = bank_q[12];
  assign reg13 = bank_q[13];
  assign reg14 = bank_q[14];
  assign reg15 = bank_q[15];

endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - streams 16 words row-major into a 4x4 operand register bank
module matrix_loader
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [IDX_W-1:0]  wr_idx,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic [DATA_W-1:0] reg6,
  output logic [DATA_W-1:0] reg7,
  output logic [DATA_W-1:0] reg8,
  output logic [DATA_W-1:0] reg9,
  output logic [DATA_W-1:0] reg10,
  output logic [DATA_W-1:0] reg11,
  output logic [DATA_W-1:0] reg12,
  output logic [DATA_W-1:0] reg13,
  output logic [DATA_W-1:0] reg14,
  output logic [DATA_W-1:0] reg15
);

  load_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             accept;
  logic             bank_wr_en;
  logic             bank_clr;

  assign accept = in_valid && (state_q == ST_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    if (clr) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end
  end

  // Handshake flags decode only registered state, never the inputs
  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD);
  assign done     = (state_q == ST_FULL);
  assign wr_idx   = idx_q;

  assign bank_clr   = rst || clr;
  assign bank_wr_en = accept && !bank_clr;

  reg_bank_16 u_bank (
    .clk     (clk),
    .clr     (bank_clr),
    .wr_en   (bank_wr_en),
    .wr_idx  (idx_q),
    .wr_data (in_data),
    .reg0    (reg0),
    .reg1    (reg1),
    .reg2    (reg2),
    .reg3    (reg3),
    .reg4    (reg4),
    .reg5    (reg5),
    .reg6    (reg6),
    .reg7    (reg7),
    .reg8    (reg8),
    .reg9    (reg9),
    .reg10   (reg10),
    .reg11   (reg11),
    .reg12   (reg12),
    .reg13   (reg13),
    .reg14   (reg14),
    .reg15   (reg15)
  );

endmodule
